load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the byte-lane data memory. It accepts load/store requests from the processor pipeline over a valid/ready handshake and sequences the memory's `EscMen`/`ReadMen`/`DataType`/`addr`/`data` controls. It captures the memory's zero-extended read data, applies sign or zero extension, and returns the load result with its destination register tag. It sits between the execute stage and the data memory and is the only master of the memory's control inputs.

## Interface
Parameters:
- `DATA_WIDTH`, 32: data word width.
- `ADDR_WIDTH`, 6: byte-address width, matching the memory's byte address.
- `READ_LATENCY`, 2: cycles `mem_ReadMen` is held before `mem_saida` is sampled; range 1..7.

Ports:
- **Clocking and reset (already decided):** one clock, `clock`. Reset is `reset`, asynchronous and active-high.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 01 = byte, 10 = halfword, 00 and 11 = word. Same encoding as the memory's `DataType`.
- `req_signed` in 1: loads only; 1 = sign-extend.
- `req_addr` in ADDR_WIDTH: byte address. Any alignment is allowed.
- `req_wdata` in DATA_WIDTH: store data, right-justified.
- `req_rd` in 5: destination register tag.
- `resp_valid` out 1: load result valid.
- `resp_ready` in 1: consumer accepts the result.
- `resp_data` out DATA_WIDTH: extended load result.
- `resp_rd` out 5: tag of the returned load.
- `mem_addr` out ADDR_WIDTH: to memory `addr`.
- `mem_data` out DATA_WIDTH: to memory `data`.
- `mem_DataType` out 2: to memory `DataType`.
- `mem_EscMen` out 1: write strobe.
- `mem_ReadMen` out 1: read enable.
- `mem_saida` in DATA_WIDTH: read data from memory, zero-extended by the memory.

## Operation
- **FSM states:** IDLE, WRITE, READ, RESP. Reset state is IDLE.
- **Registered outputs:** all outputs except `req_ready` are registers.
- **`req_ready`:** equals `(state==IDLE) & ~reset`.
- **Request capture:** an accept is `req_valid & req_ready` on a rising edge. On accept, latch `addr`, `wdata`, `size`, `signed` and `rd` into request registers. `mem_addr`, `mem_data` and `mem_DataType` are driven from these registers and stay stable for the whole operation.
- **IDLE:**
  - Accept with `req_write=1` → WRITE.
  - Accept with `req_write=0` → READ, with read counter = 0.
  - No accept → stay in IDLE.
- **WRITE:**
  - `mem_EscMen=1` for exactly one cycle, then → IDLE.
  - Stores produce no response.
- **READ:**
  - `mem_ReadMen=1` every READ cycle.
  - The counter increments each cycle.
  - When the counter reaches READ_LATENCY-1, on that edge: sample `mem_saida`, extend it, load `resp_data`/`resp_rd`, set `resp_valid=1`, and go → RESP.
- **RESP:**
  - `mem_ReadMen=0`.
  - Hold `resp_valid`, `resp_data` and `resp_rd` stable until `resp_valid & resp_ready`, then clear `resp_valid` and go → IDLE.
- **Extension:**
  - byte: bits [31:8] = `req_signed` ? `mem_saida[7]` : 0.
  - halfword: bits [31:16] = `req_signed` ? `mem_saida[15]` : 0.
  - word: `mem_saida` unmodified.
  - Upper bits of `mem_saida` are ignored for byte and halfword loads.
- **Misaligned and wrapping addresses:** passed through unchanged. The memory handles lane rotation and wrap-around modulo 2^ADDR_WIDTH, e.g. a word at address 63 wraps to 0..2. The unit does no alignment checks.
- **Illegal `req_size` values:** 00 and 11 are both treated as word for extension.
- **Reset:**
  - Asserting `reset` at any point forces IDLE immediately (asynchronous).
  - It clears `mem_EscMen`, `mem_ReadMen`, `resp_valid` and the counter, and discards any in-flight request.
  - A store interrupted before its WRITE cycle is not performed.

## Timing
- **Reset values:** `mem_EscMen`=0, `mem_ReadMen`=0, `resp_valid`=0, `resp_data`=0, `resp_rd`=0, `mem_addr`=0, `mem_data`=0, `mem_DataType`=0. `req_ready` is 0 while `reset` is high and 1 in the first cycle after release.
- **Store:** accept at edge N; `mem_EscMen` is high during cycle N..N+1 (one clock); `req_ready` is high again from edge N+2. Throughput is one store per 2 cycles.
- **Load:** accept at edge N; `mem_ReadMen` is high for READ_LATENCY cycles; `resp_valid` rises at edge N+READ_LATENCY. Minimum load occupancy is READ_LATENCY+1 cycles with `resp_ready` held high.
- **Response back-pressure:** while RESP waits, `req_ready`=0, so no new request is accepted.
- **No same-edge turnaround:** a response handshake and a new-request accept can never fall on the same edge, because `req_ready`=0 in RESP.
- **Memory interface:** `mem_addr`, `mem_DataType` and `mem_data` change only on an accept edge.

## Test plan
- **Reset mid-load:** reset high 3 cycles, then a load is accepted; assert reset during READ → `mem_ReadMen`, `resp_valid` and `mem_EscMen` go to 0 asynchronously. After release, `req_ready`=1 and no response appears.
- **Word store:** `addr`=0x05, `size`=11, `wdata`=0xDEADBEEF → `mem_EscMen` is a single one-cycle pulse with `mem_addr`=0x05, `mem_DataType`=11, `mem_data`=0xDEADBEEF. `req_ready` returns after 2 cycles.
- **Signed byte load:** `size`=01, `signed`=1, `mem_saida`=0x000000F0 → `resp_data`=0xFFFFFFF0 at edge N+READ_LATENCY, `resp_rd` equals the request tag.
- **Unsigned halfword load:** `size`=10, `signed`=0, `mem_saida`=0xFFFF8001 → `resp_data`=0x00008001. The same load with `signed`=1 → 0xFFFF8001.
- **Response back-pressure:** `resp_ready`=0 for 5 cycles → `resp_valid`, `resp_data` and `resp_rd` stay stable and `req_ready`=0, with a pending `req_valid` not accepted. The response handshake completes on the first edge `resp_ready` is high, and the pending request is accepted 1 cycle later.
- **Wrapping word load:** `addr`=63, word `size`, `mem_saida`=0x11223344 → `mem_addr`=63 throughout the operation and `resp_data`=0x11223344 unmodified.

Source files
------------

// File: rtl/load_store_unit_if.sv
// load_store_unit_if
//   Bundles the three channels around the load/store unit:
//     request  : req_valid/req_ready handshake plus write, size, signed,
//                addr, wdata and rd (destination tag)
//     response : resp_valid/resp_ready handshake plus data and rd
//     memory   : addr, data, DataType, EscMen, ReadMen out; saida back in
//   modport slave  - the load/store unit itself
//   modport master - whatever drives requests and models the memory
interface load_store_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [4:0]            req_rd;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_data;
    logic [4:0]            resp_rd;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [1:0]            mem_DataType;
    logic                  mem_EscMen;
    logic                  mem_ReadMen;
    logic [DATA_WIDTH-1:0] mem_saida;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, req_rd,
        input  resp_ready, mem_saida,
        output req_ready, resp_valid, resp_data, resp_rd,
        output mem_addr, mem_data, mem_DataType, mem_EscMen, mem_ReadMen
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, req_rd,
        output resp_ready, mem_saida,
        input  req_ready, resp_valid, resp_data, resp_rd,
        input  mem_addr, mem_data, mem_DataType, mem_EscMen, mem_ReadMen
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator for the byte-lane data memory. Accepts one load or store at a
//   time, drives the memory controls from registered copies of the request,
//   and returns sign/zero-extended load data with its register tag.
//   Ports:
//     clock - rising-edge clock
//     reset - asynchronous, active-high
//     bus   - load_store_unit_if.slave (request, response and memory channels)
module load_store_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 6,
    parameter int READ_LATENCY = 2
) (
    input logic               clock,
    input logic               reset,
    load_store_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} lsuState;

    // Counter value on the cycle the memory read data is valid.
    localparam logic [2:0] lastCount = 3'(READ_LATENCY - 1);

    lsuState    state, nextState;
    logic [2:0] readCount, nextCount;
    logic       reqSigned;
    logic [4:0] reqRd;
    logic       accept;
    logic       readDone;
    logic       respDone;

    // Memory returns zero-extended data; only the lanes selected by the
    // latched size are kept, upper bits are replaced by the extension.
    function automatic logic [DATA_WIDTH-1:0] extend(
        input logic [DATA_WIDTH-1:0] raw,
        input logic [1:0]            size,
        input logic                  isSigned
    );
        case (size)
            2'b01:   extend = {{(DATA_WIDTH-8){isSigned & raw[7]}}, raw[7:0]};
            2'b10:   extend = {{(DATA_WIDTH-16){isSigned & raw[15]}}, raw[15:0]};
            default: extend = raw;  // 00 and 11 both mean word
        endcase
    endfunction

    // Combinational so a request can be accepted on the first edge after
    // reset is released.
    assign bus.req_ready = (state == IDLE) & ~reset;

    assign accept   = bus.req_valid & bus.req_ready;
    assign readDone = (state == READ) && (readCount == lastCount);
    assign respDone = (state == RESP) && bus.resp_valid && bus.resp_ready;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        nextState = state;
        nextCount = readCount;
        case (state)
            IDLE: begin
                if (accept) begin
                    nextState = bus.req_write ? WRITE : READ;
                    nextCount = '0;
                end
            end
            WRITE: nextState = IDLE;
            READ: begin
                nextCount = readCount + 3'd1;
                if (readDone) nextState = RESP;
            end
            RESP: begin
                if (respDone) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            readCount   <= '0;
            reqSigned   <= 1'b0;
            reqRd       <= '0;
            bus.mem_addr     <= '0;
            bus.mem_data     <= '0;
            bus.mem_DataType <= '0;
            bus.mem_EscMen   <= 1'b0;
            bus.mem_ReadMen  <= 1'b0;
            bus.resp_valid   <= 1'b0;
            bus.resp_data    <= '0;
            bus.resp_rd      <= '0;
        end else begin
            state     <= nextState;
            readCount <= nextCount;

            // Strobes follow the state being entered, so they are high for
            // exactly the cycles spent in WRITE / READ.
            bus.mem_EscMen  <= (nextState == WRITE);
            bus.mem_ReadMen <= (nextState == READ);

            // Request registers double as the memory address/data/size
            // outputs, keeping them stable for the whole operation.
            if (accept) begin
                bus.mem_addr     <= bus.req_addr;
                bus.mem_data     <= bus.req_wdata;
                bus.mem_DataType <= bus.req_size;
                reqSigned        <= bus.req_signed;
                reqRd            <= bus.req_rd;
            end

            if (readDone) begin
                bus.resp_valid <= 1'b1;
                bus.resp_data  <= extend(bus.mem_saida, bus.mem_DataType, reqSigned);
                bus.resp_rd    <= reqRd;
            end else if (respDone) begin
                bus.resp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Drives directed and random loads/stores into load_store_unit, models the
//   byte-lane memory on the other side, and compares results against a
//   byte-array reference of what memory should contain.
module tb_load_store_unit;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int RL = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    load_store_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) lsu ();

    load_store_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (lsu.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  refMem [64] = '{default: 8'h00};
    logic [7:0]  devMem [64] = '{default: 8'h00};
    int          readHeld = 0;
    logic [31:0] junk = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int sizeBytes(input logic [1:0] sz);
        return (sz == 2'b01) ? 1 : (sz == 2'b10) ? 2 : 4;
    endfunction

    // Memory device: writes on EscMen, and only presents real read data once
    // ReadMen has been held for RL-1 prior cycles; otherwise (and in unused
    // upper lanes) it drives garbage.
    always @(posedge clock) begin
        junk     <= $urandom;
        readHeld <= lsu.mem_ReadMen ? readHeld + 1 : 0;
        if (lsu.mem_EscMen)
            for (int i = 0; i < sizeBytes(lsu.mem_DataType); i++)
                devMem[(int'(lsu.mem_addr) + i) % 64] <= lsu.mem_data[8*i +: 8];
    end

    always_comb begin
        lsu.mem_saida = junk;
        if (lsu.mem_ReadMen && readHeld == RL - 1)
            for (int i = 0; i < 4; i++)
                if (i < sizeBytes(lsu.mem_DataType))
                    lsu.mem_saida[8*i +: 8] = devMem[(int'(lsu.mem_addr) + i) % 64];
    end

    function automatic void refStore(input logic [5:0] a, input logic [1:0] sz, input logic [31:0] d);
        for (int i = 0; i < sizeBytes(sz); i++)
            refMem[(int'(a) + i) % 64] = d[8*i +: 8];
    endfunction

    function automatic logic [31:0] refLoad(input logic [5:0] a, input logic [1:0] sz, input logic sg);
        int n;
        logic [31:0] v;
        n = sizeBytes(sz);
        v = 32'h0;
        for (int i = 0; i < n; i++)
            v = v | (32'(refMem[(int'(a) + i) % 64]) << (8 * i));
        if (sg && n < 4 && v[8*n-1])
            v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Presents a request, waits (bounded) for ready, and returns just after
    // the accept edge with req_valid dropped.
    task automatic present(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [5:0] a, input logic [31:0] d, input logic [4:0] rd);
        int waitCycles;
        waitCycles     = 0;
        lsu.req_valid  = 1'b1;
        lsu.req_write  = w;
        lsu.req_size   = sz;
        lsu.req_signed = sg;
        lsu.req_addr   = a;
        lsu.req_wdata  = d;
        lsu.req_rd     = rd;
        while (!lsu.req_ready && waitCycles < 20) begin
            tick();
            waitCycles++;
        end
        check("req_ready_wait", 32'(lsu.req_ready), 32'd1);
        tick();
        lsu.req_valid = 1'b0;
    endtask

    task automatic doStore(input logic [5:0] a, input logic [1:0] sz, input logic [31:0] d);
        present(1'b1, sz, 1'b0, a, d, 5'd0);
        check("st_escmen", 32'(lsu.mem_EscMen), 32'd1);
        check("st_addr", 32'(lsu.mem_addr), 32'(a));
        check("st_type", 32'(lsu.mem_DataType), 32'(sz));
        check("st_data", lsu.mem_data, d);
        check("st_busy", 32'(lsu.req_ready), 32'd0);
        tick();
        check("st_escmen_off", 32'(lsu.mem_EscMen), 32'd0);
        check("st_ready_back", 32'(lsu.req_ready), 32'd1);
        refStore(a, sz, d);
    endtask

    // Load with optional response back-pressure; with pend set, a store is
    // held pending on the request channel during the wait.
    task automatic doLoad(input logic [5:0] a, input logic [1:0] sz, input logic sg,
                          input logic [4:0] rd, input int hold, input bit pend);
        logic [31:0] exp;
        int cycles;
        exp    = refLoad(a, sz, sg);
        cycles = 0;
        present(1'b0, sz, sg, a, 32'h0, rd);
        while (!lsu.resp_valid && cycles < 20) begin
            check("ld_readmen", 32'(lsu.mem_ReadMen), 32'd1);
            check("ld_addr", 32'(lsu.mem_addr), 32'(a));
            tick();
            cycles++;
        end
        check("ld_latency", 32'(cycles), 32'(RL));
        check("ld_data", lsu.resp_data, exp);
        check("ld_rd", 32'(lsu.resp_rd), 32'(rd));
        check("ld_readmen_off", 32'(lsu.mem_ReadMen), 32'd0);
        if (pend) begin
            lsu.req_valid  = 1'b1;
            lsu.req_write  = 1'b1;
            lsu.req_size   = 2'b01;
            lsu.req_addr   = 6'd40;
            lsu.req_wdata  = 32'h0000_005A;
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            check("bp_valid", 32'(lsu.resp_valid), 32'd1);
            check("bp_data", lsu.resp_data, exp);
            check("bp_rd", 32'(lsu.resp_rd), 32'(rd));
            check("bp_ready", 32'(lsu.req_ready), 32'd0);
            check("bp_escmen", 32'(lsu.mem_EscMen), 32'd0);
        end
        lsu.resp_ready = 1'b1;
        tick();
        lsu.resp_ready = 1'b0;
        check("hs_valid_clear", 32'(lsu.resp_valid), 32'd0);
        check("hs_ready", 32'(lsu.req_ready), 32'd1);
        if (pend) begin
            check("pend_not_yet", 32'(lsu.mem_EscMen), 32'd0);
            tick();
            lsu.req_valid = 1'b0;
            check("pend_accept", 32'(lsu.mem_EscMen), 32'd1);
            check("pend_addr", 32'(lsu.mem_addr), 32'd40);
            refStore(6'd40, 2'b01, 32'h0000_005A);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        lsu.req_valid  = 1'b0;
        lsu.req_write  = 1'b0;
        lsu.req_size   = 2'b00;
        lsu.req_signed = 1'b0;
        lsu.req_addr   = '0;
        lsu.req_wdata  = '0;
        lsu.req_rd     = '0;
        lsu.resp_ready = 1'b0;

        // Reset values after three reset cycles.
        repeat (3) tick();
        check("rst_escmen", 32'(lsu.mem_EscMen), 32'd0);
        check("rst_readmen", 32'(lsu.mem_ReadMen), 32'd0);
        check("rst_resp_valid", 32'(lsu.resp_valid), 32'd0);
        check("rst_resp_data", lsu.resp_data, 32'd0);
        check("rst_resp_rd", 32'(lsu.resp_rd), 32'd0);
        check("rst_mem_addr", 32'(lsu.mem_addr), 32'd0);
        check("rst_mem_data", lsu.mem_data, 32'd0);
        check("rst_mem_type", 32'(lsu.mem_DataType), 32'd0);
        check("rst_req_ready", 32'(lsu.req_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("rel_req_ready", 32'(lsu.req_ready), 32'd1);

        // Reset in the middle of a load.
        present(1'b0, 2'b11, 1'b0, 6'd4, 32'h0, 5'd9);
        check("mid_readmen", 32'(lsu.mem_ReadMen), 32'd1);
        #3 reset = 1'b1;
        #1;
        check("mid_rst_readmen", 32'(lsu.mem_ReadMen), 32'd0);
        check("mid_rst_valid", 32'(lsu.resp_valid), 32'd0);
        check("mid_rst_escmen", 32'(lsu.mem_EscMen), 32'd0);
        check("mid_rst_ready", 32'(lsu.req_ready), 32'd0);
        tick();
        reset = 1'b0;
        repeat (4) begin
            tick();
            check("mid_no_resp", 32'(lsu.resp_valid), 32'd0);
        end
        check("mid_ready", 32'(lsu.req_ready), 32'd1);

        // Store cut off by reset during WRITE never reaches memory.
        present(1'b1, 2'b11, 1'b0, 6'd30, 32'hCAFE_F00D, 5'd0);
        check("cut_escmen", 32'(lsu.mem_EscMen), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("cut_escmen_off", 32'(lsu.mem_EscMen), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Directed cases.
        doStore(6'h05, 2'b11, 32'hDEAD_BEEF);
        doStore(6'd10, 2'b01, 32'h0000_00F0);
        doLoad(6'd10, 2'b01, 1'b1, 5'd7, 0, 1'b0);
        doStore(6'd20, 2'b10, 32'h0000_8001);
        doLoad(6'd20, 2'b10, 1'b0, 5'd12, 0, 1'b0);
        doLoad(6'd20, 2'b10, 1'b1, 5'd13, 0, 1'b0);
        doStore(6'd63, 2'b00, 32'h1122_3344);
        doLoad(6'd63, 2'b11, 1'b0, 5'd31, 5, 1'b1);
        doLoad(6'd30, 2'b11, 1'b0, 5'd3, 0, 1'b0);
        doLoad(6'd05, 2'b00, 1'b1, 5'd1, 1, 1'b0);

        // Random mix.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 1) == 1)
                doStore(6'($urandom_range(0, 63)), 2'($urandom), $urandom);
            else
                doLoad(6'($urandom_range(0, 63)), 2'($urandom), 1'($urandom),
                       5'($urandom), int'($urandom_range(0, 2)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
